bus_cycle_monitor: RTL and testbench
====================================

// Module: bus_cycle_monitor
// PURPOSE
//  Clocked companion to the combinational 68000 address decoder. Generates the
//  BOOT overlay signal the decoder consumes and supplies wait-stated DTACK for
//  the I/O region the decoder selects. Also watches every CPU bus cycle and
//  raises BERR when no DTACK arrives, so a bad access never hangs the CPU.
// PARAMETERS
//  IO_WAIT       2    clocks from cycle start to I/O DTACK; legal 1..BERR_TIMEOUT-1
//  BERR_TIMEOUT  64   clocks from cycle start to bus error; legal 2..2**CNT_W-1
//  BOOT_CYCLES   4    completed bus cycles before BOOT goes high (SSP+PC fetch = 4 words)
//  CNT_W         8    width of cycle counter
// PORTS
//  i_CLK          in   1   system clock
//  i_RESET        in   1   synchronous reset, active-high
//  i_AS_n         in   1   CPU address strobe, asynchronous
//  i_IOSEL_n      in   1   I/O select from decoder, stable while AS low
//  i_DTACK_n      in   1   wired-OR bus DTACK (decoder PPDTACK, expansion), asynchronous
//  o_IODTACK      out  1   1 = drive bus DTACK low (external open-drain buffer)
//  o_BERR_n       out  1   bus error to CPU, active-low
//  o_BOOT         out  1   0 = boot overlay (ROM at 0 for reads); to decoder i_BOOT
//  [BUS_FAULT_LATCH_EN] i_A in 23 (A[23:1]); i_FAULT_CLR in 1; o_FAULT_ADDR out 23; o_FAULT_VALID out 1
// BEHAVIOUR
//  - i_AS_n, i_DTACK_n each pass through 2-FF synchronizer (as_s, dt_s); reset value 1.
//  - All outputs registered (Moore). Reset: o_IODTACK=0, o_BERR_n=1, o_BOOT=0,
//    state=IDLE, cnt=0, boot_cnt=0, o_FAULT_VALID=0, o_FAULT_ADDR=0.
//  - States: IDLE, CYCLE, ACK, DONE, BERR.
//  - IDLE: as_s==0 -> CYCLE, cnt<=0, io<=!i_IOSEL_n.
//  - CYCLE: cnt<=cnt+1 every clock. Priority, highest first:
//     1 as_s==1 -> IDLE (aborted cycle; does not count toward boot)
//     2 io && cnt==IO_WAIT-1 -> ACK
//     3 !io && dt_s==0 -> DONE
//     4 cnt==BERR_TIMEOUT-1 -> BERR
//  - ACK: o_IODTACK=1; stay until as_s==1 -> IDLE.
//  - DONE: stay until as_s==1 -> IDLE.
//  - BERR: o_BERR_n=0; stay until as_s==1 -> IDLE.
//  - Timing: E1 = first edge sampling i_AS_n low; CYCLE entered at E3.
//    o_IODTACK high after E(3+IO_WAIT); o_BERR_n low after E(3+BERR_TIMEOUT).
//  - Completed cycle = ACK->IDLE or DONE->IDLE. BERR, abort: not counted.
//    While o_BOOT==0: boot_cnt++ on each completed cycle.
//    When boot_cnt reaches BOOT_CYCLES, o_BOOT<=1 on that same edge.
//    o_BOOT is sticky until reset; boot_cnt saturates.
//  - io in CYCLE ignores dt_s; I/O is always acked by this block, never times out.
//  - cnt never wraps: BERR_TIMEOUT-1 < 2**CNT_W guaranteed by parameter range.
//  - Reset mid-cycle: reset wins; all outputs return to reset values on next edge.
//  - AS re-asserted in same clock state returns to IDLE: handled next clock (IDLE sees as_s==0).
// CONFIGURATION
//  BUS_FAULT_LATCH_EN defined: on CYCLE->BERR, o_FAULT_ADDR<=i_A, o_FAULT_VALID<=1.
//    Only first fault is latched while VALID=1. i_FAULT_CLR clears VALID.
//    If clear and fault land on the same edge, the new fault wins (VALID=1, new addr).
//  BUS_FAULT_LATCH_EN undefined: fault ports absent; no latch logic.
// TESTING
//  1 Reset held 3 clocks -> o_IODTACK=0, o_BERR_n=1, o_BOOT=0.
//  2 Four ROM reads, i_DTACK_n low 4 clk after AS -> o_BOOT=1 after 4th AS rise.
//    5th cycle does not toggle o_BOOT.
//  3 IO_WAIT=2, AS low with i_IOSEL_n=0 at E1 -> o_IODTACK=1 after E5.
//    o_IODTACK drops 3 clk after AS rises.
//  4 AS low, no DTACK, BERR_TIMEOUT=64 -> o_BERR_n=0 after E67; held until AS high.
//    boot_cnt unchanged.
//  5 AS pulse of 3 clk, no DTACK -> abort to IDLE; no BERR, no IODTACK, no boot count.
//  6 [FAULT_LATCH] i_A=23'h7A0000 timeout -> o_FAULT_ADDR=7A0000, VALID=1.
//    Second fault keeps 7A0000. i_FAULT_CLR -> VALID=0.

Source files
------------

// File: rtl/bus_cycle_monitor.sv
// Bus cycle monitor: BOOT overlay generation, wait-stated I/O DTACK and bus-error timeout for the 68000.
// Optional fault address latch enabled by defining BUS_FAULT_LATCH_EN.
module bus_cycle_monitor #(
    parameter int IO_WAIT      = 2,
    parameter int BERR_TIMEOUT = 64,
    parameter int BOOT_CYCLES  = 4,
    parameter int CNT_W        = 8
) (
    input  logic        i_CLK,
    input  logic        i_RESET,
    input  logic        i_AS_n,
    input  logic        i_IOSEL_n,
    input  logic        i_DTACK_n,
`ifdef BUS_FAULT_LATCH_EN
    input  logic [23:1] i_A,
    input  logic        i_FAULT_CLR,
    output logic [23:1] o_FAULT_ADDR,
    output logic        o_FAULT_VALID,
`endif
    output logic        o_IODTACK,
    output logic        o_BERR_n,
    output logic        o_BOOT
);

    localparam int BW = $clog2(BOOT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CYCLE = 3'd1,
        S_ACK   = 3'd2,
        S_DONE  = 3'd3,
        S_BERR  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              io_q, io_d;
    logic [BW-1:0]     boot_cnt_q, boot_cnt_d;
    logic              boot_q, boot_d;
    logic              iodtack_q, iodtack_d;
    logic              berr_n_q, berr_n_d;

    logic              as_meta_q, as_s_q;
    logic              dt_meta_q, dt_s_q;

    logic              cycle_done;
    logic              berr_entry;

`ifdef BUS_FAULT_LATCH_EN
    logic [23:1]       fault_addr_q, fault_addr_d;
    logic              fault_valid_q, fault_valid_d;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        io_d       = io_q;
        boot_cnt_d = boot_cnt_q;
        boot_d     = boot_q;
        cycle_done = 1'b0;
        berr_entry = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!as_s_q) begin
                    state_d = S_CYCLE;
                    cnt_d   = '0;
                    io_d    = !i_IOSEL_n;
                end
            end
            S_CYCLE: begin
                cnt_d = cnt_q + 1'b1;
                // Abort outranks everything; I/O ack outranks external DTACK and timeout.
                if (as_s_q) begin
                    state_d = S_IDLE;
                end else if (io_q && (cnt_q == CNT_W'(IO_WAIT - 1))) begin
                    state_d = S_ACK;
                end else if (!io_q && !dt_s_q) begin
                    state_d = S_DONE;
                end else if (cnt_q == CNT_W'(BERR_TIMEOUT - 1)) begin
                    state_d    = S_BERR;
                    berr_entry = 1'b1;
                end
            end
            S_ACK, S_DONE: begin
                if (as_s_q) begin
                    state_d    = S_IDLE;
                    cycle_done = 1'b1;
                end
            end
            S_BERR: begin
                if (as_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (cycle_done && !boot_q) begin
            boot_cnt_d = boot_cnt_q + 1'b1;
            if (boot_cnt_d == BW'(BOOT_CYCLES)) begin
                boot_d = 1'b1;
            end
        end

        iodtack_d = (state_d == S_ACK);
        berr_n_d  = (state_d != S_BERR);
    end

`ifdef BUS_FAULT_LATCH_EN
    // A fresh fault on the clearing edge replaces the old one rather than being lost.
    always_comb begin
        fault_addr_d  = fault_addr_q;
        fault_valid_d = fault_valid_q;
        if (berr_entry && (!fault_valid_q || i_FAULT_CLR)) begin
            fault_addr_d  = i_A;
            fault_valid_d = 1'b1;
        end else if (i_FAULT_CLR) begin
            fault_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            fault_addr_q  <= '0;
            fault_valid_q <= 1'b0;
        end else begin
            fault_addr_q  <= fault_addr_d;
            fault_valid_q <= fault_valid_d;
        end
    end

    assign o_FAULT_ADDR  = fault_addr_q;
    assign o_FAULT_VALID = fault_valid_q;
`endif

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            as_meta_q  <= 1'b1;
            as_s_q     <= 1'b1;
            dt_meta_q  <= 1'b1;
            dt_s_q     <= 1'b1;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            io_q       <= 1'b0;
            boot_cnt_q <= '0;
            boot_q     <= 1'b0;
            iodtack_q  <= 1'b0;
            berr_n_q   <= 1'b1;
        end else begin
            as_meta_q  <= i_AS_n;
            as_s_q     <= as_meta_q;
            dt_meta_q  <= i_DTACK_n;
            dt_s_q     <= dt_meta_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            io_q       <= io_d;
            boot_cnt_q <= boot_cnt_d;
            boot_q     <= boot_d;
            iodtack_q  <= iodtack_d;
            berr_n_q   <= berr_n_d;
        end
    end

    assign o_IODTACK = iodtack_q;
    assign o_BERR_n  = berr_n_q;
    assign o_BOOT    = boot_q;

endmodule

// File: tb/tb_bus_cycle_monitor.sv
// Directed bench for bus_cycle_monitor: reset, boot counting, I/O ack timing, timeout, abort, optional fault latch.
module tb_bus_cycle_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        as_n;
    logic        iosel_n;
    logic        dtack_n;
    logic        iodtack;
    logic        berr_n;
    logic        boot;
`ifdef BUS_FAULT_LATCH_EN
    logic [23:1] addr;
    logic        fault_clr;
    logic [23:1] fault_addr;
    logic        fault_valid;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    bus_cycle_monitor #(
        .IO_WAIT      (2),
        .BERR_TIMEOUT (64),
        .BOOT_CYCLES  (4),
        .CNT_W        (8)
    ) dut (
        .i_CLK         (clk),
        .i_RESET       (rst),
        .i_AS_n        (as_n),
        .i_IOSEL_n     (iosel_n),
        .i_DTACK_n     (dtack_n),
`ifdef BUS_FAULT_LATCH_EN
        .i_A           (addr),
        .i_FAULT_CLR   (fault_clr),
        .o_FAULT_ADDR  (fault_addr),
        .o_FAULT_VALID (fault_valid),
`endif
        .o_IODTACK     (iodtack),
        .o_BERR_n      (berr_n),
        .o_BOOT        (boot)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // External DTACK asserted 4 clocks after AS; AS released 8 clocks after assertion.
    task automatic rom_read(input logic boot_pre, input logic boot_post);
        as_n    = 1'b0;
        iosel_n = 1'b1;
        tick(4);
        dtack_n = 1'b0;
        tick(4);
        check("rom_berr_n", berr_n, 1'b1);
        as_n    = 1'b1;
        dtack_n = 1'b1;
        tick(2);
        check("rom_boot_pre", boot, boot_pre);
        tick(1);
        check("rom_boot_post", boot, boot_post);
        tick(2);
    endtask

    task automatic io_cycle(input logic boot_pre, input logic boot_post);
        as_n    = 1'b0;
        iosel_n = 1'b0;
        tick(4);
        check("io_ack_e4", iodtack, 1'b0);
        tick(1);
        check("io_ack_e5", iodtack, 1'b1);
        tick(3);
        check("io_ack_hold", iodtack, 1'b1);
        check("io_berr_n", berr_n, 1'b1);
        as_n = 1'b1;
        tick(2);
        check("io_ack_f2", iodtack, 1'b1);
        check("io_boot_pre", boot, boot_pre);
        tick(1);
        check("io_ack_f3", iodtack, 1'b0);
        check("io_boot_post", boot, boot_post);
        iosel_n = 1'b1;
        tick(2);
    endtask

    initial begin
        rst     = 1'b1;
        as_n    = 1'b1;
        iosel_n = 1'b1;
        dtack_n = 1'b1;
`ifdef BUS_FAULT_LATCH_EN
        addr      = '0;
        fault_clr = 1'b0;
`endif
        #1;
        tick(3);
        check("rst_iodtack", iodtack, 1'b0);
        check("rst_berr_n", berr_n, 1'b1);
        check("rst_boot", boot, 1'b0);
`ifdef BUS_FAULT_LATCH_EN
        check("rst_fvalid", fault_valid, 1'b0);
        check("rst_faddr", fault_addr, 23'h0);
`endif
        rst = 1'b0;
        tick(2);

        // Short AS pulse: cycle aborts with neither ack nor error.
        as_n = 1'b0;
        tick(3);
        as_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("abort_iodtack", iodtack, 1'b0);
            check("abort_berr_n", berr_n, 1'b1);
        end

        // Unanswered cycle times out after E67.
        as_n    = 1'b0;
        iosel_n = 1'b1;
`ifdef BUS_FAULT_LATCH_EN
        addr = 23'h7A0000;
`endif
        tick(66);
        check("berr_e66", berr_n, 1'b1);
        tick(1);
        check("berr_e67", berr_n, 1'b0);
        check("berr_no_ack", iodtack, 1'b0);
        tick(5);
        check("berr_hold", berr_n, 1'b0);
`ifdef BUS_FAULT_LATCH_EN
        check("fault_valid1", fault_valid, 1'b1);
        check("fault_addr1", fault_addr, 23'h7A0000);
`endif
        as_n = 1'b1;
        tick(2);
        check("berr_f2", berr_n, 1'b0);
        tick(1);
        check("berr_f3", berr_n, 1'b1);
        check("berr_boot", boot, 1'b0);
        tick(2);

        // Abort and bus error did not count: BOOT rises exactly on the 4th completed read.
        rom_read(1'b0, 1'b0);
        rom_read(1'b0, 1'b0);
        rom_read(1'b0, 1'b0);
        rom_read(1'b0, 1'b1);
        rom_read(1'b1, 1'b1);

        io_cycle(1'b1, 1'b1);

        // Reset in the middle of an acked I/O cycle.
        as_n    = 1'b0;
        iosel_n = 1'b0;
        tick(6);
        check("mid_ack_pre", iodtack, 1'b1);
        rst = 1'b1;
        tick(1);
        check("mid_rst_ack", iodtack, 1'b0);
        check("mid_rst_boot", boot, 1'b0);
        check("mid_rst_berr_n", berr_n, 1'b1);
        as_n    = 1'b1;
        iosel_n = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);

        // I/O completions count toward boot as well.
        rom_read(1'b0, 1'b0);
        rom_read(1'b0, 1'b0);
        rom_read(1'b0, 1'b0);
        io_cycle(1'b0, 1'b1);

`ifdef BUS_FAULT_LATCH_EN
        // Second fault while valid keeps the first address.
        as_n = 1'b0;
        addr = 23'h123456;
        tick(67);
        check("fault2_berr", berr_n, 1'b0);
        check("fault2_valid", fault_valid, 1'b1);
        check("fault2_addr", fault_addr, 23'h7A0000);
        as_n = 1'b1;
        tick(4);
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        check("fault_clr_valid", fault_valid, 1'b0);
        tick(2);

        // Clear and new fault on the same edge: new fault wins.
        as_n = 1'b0;
        addr = 23'h055555;
        tick(66);
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        check("fault_race_berr", berr_n, 1'b0);
        check("fault_race_valid", fault_valid, 1'b1);
        check("fault_race_addr", fault_addr, 23'h055555);
        as_n = 1'b1;
        tick(4);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
